// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with bubble insertion on flush and, when LOAD_USE_DETECT_EN
// is defined, load-use hazard detection with a saturating bubble counter.
module id_ex_pipe (
    input  logic        clk,
    input  logic        rstn,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rd1,
    input  logic [31:0] id_rd2,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [2:0]  id_funct3,
    input  logic        id_RegWrite,
    input  logic        id_MemWrite,
    input  logic        id_MemRead,
    input  logic        id_ALUSrc,
    input  logic [4:0]  id_ALUOp,
    input  logic [4:0]  id_NPCOp,
    input  logic [1:0]  id_WDSel,
    input  logic        flush,
    input  logic        hold,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rd1,
    output logic [31:0] ex_rd2,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic        ex_use_rs1,
    output logic        ex_use_rs2,
    output logic [2:0]  ex_funct3,
    output logic        ex_RegWrite,
    output logic        ex_MemWrite,
    output logic        ex_MemRead,
    output logic        ex_ALUSrc,
    output logic [4:0]  ex_ALUOp,
    output logic [4:0]  ex_NPCOp,
    output logic [1:0]  ex_WDSel,
    output logic        load_use_stall,
    output logic [15:0] bubble_cnt
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'd0,
        MODE_BUBBLE = 2'd1,
        MODE_LOAD   = 2'd2
    } mode_t;

    mode_t       mode_s;
    logic        hazard_s;

    logic        valid_r,    valid_nxt_s;
    logic [31:0] pc_r,       pc_nxt_s;
    logic [31:0] rd1_r,      rd1_nxt_s;
    logic [31:0] rd2_r,      rd2_nxt_s;
    logic [31:0] imm_r,      imm_nxt_s;
    logic [4:0]  rs1_r,      rs1_nxt_s;
    logic [4:0]  rs2_r,      rs2_nxt_s;
    logic [4:0]  rd_r,       rd_nxt_s;
    logic        use_rs1_r,  use_rs1_nxt_s;
    logic        use_rs2_r,  use_rs2_nxt_s;
    logic [2:0]  funct3_r,   funct3_nxt_s;
    logic        regwrite_r, regwrite_nxt_s;
    logic        memwrite_r, memwrite_nxt_s;
    logic        memread_r,  memread_nxt_s;
    logic        alusrc_r,   alusrc_nxt_s;
    logic [4:0]  aluop_r,    aluop_nxt_s;
    logic [4:0]  npcop_r,    npcop_nxt_s;
    logic [1:0]  wdsel_r,    wdsel_nxt_s;
    logic [15:0] cnt_r,      cnt_nxt_s;

    // Load-use hazard: the load in EX writes a register the ID instruction reads.
    always_comb begin
        hazard_s = 1'b0;
`ifdef LOAD_USE_DETECT_EN
        if (valid_r && memread_r && (rd_r != 5'd0) && id_valid) begin
            hazard_s = (id_use_rs1 && (id_rs1 == rd_r)) ||
                       (id_use_rs2 && (id_rs2 == rd_r));
        end else begin
            hazard_s = 1'b0;
        end
`endif
    end

    // A wrong-path instruction being flushed never needs the front end to stall.
    assign load_use_stall = hazard_s & ~flush;

    // Edge action selection: hold beats flush beats hazard beats a normal load.
    always_comb begin
        mode_s = MODE_LOAD;
        if (hold) begin
            mode_s = MODE_HOLD;
        end else if (flush || hazard_s) begin
            mode_s = MODE_BUBBLE;
        end else begin
            mode_s = MODE_LOAD;
        end
    end

    // Next-state values for every EX register according to the selected action.
    always_comb begin
        valid_nxt_s    = valid_r;
        pc_nxt_s       = pc_r;
        rd1_nxt_s      = rd1_r;
        rd2_nxt_s      = rd2_r;
        imm_nxt_s      = imm_r;
        rs1_nxt_s      = rs1_r;
        rs2_nxt_s      = rs2_r;
        rd_nxt_s       = rd_r;
        use_rs1_nxt_s  = use_rs1_r;
        use_rs2_nxt_s  = use_rs2_r;
        funct3_nxt_s   = funct3_r;
        regwrite_nxt_s = regwrite_r;
        memwrite_nxt_s = memwrite_r;
        memread_nxt_s  = memread_r;
        alusrc_nxt_s   = alusrc_r;
        aluop_nxt_s    = aluop_r;
        npcop_nxt_s    = npcop_r;
        wdsel_nxt_s    = wdsel_r;
        cnt_nxt_s      = cnt_r;
        case (mode_s)
            MODE_HOLD: begin
                cnt_nxt_s = cnt_r;
            end
            MODE_BUBBLE: begin
                // Datapath fields keep their old (reset-defined) contents in a bubble.
                valid_nxt_s    = 1'b0;
                regwrite_nxt_s = 1'b0;
                memwrite_nxt_s = 1'b0;
                memread_nxt_s  = 1'b0;
                npcop_nxt_s    = 5'd0;
                wdsel_nxt_s    = 2'd0;
                cnt_nxt_s      = (cnt_r == 16'hFFFF) ? cnt_r : (cnt_r + 16'd1);
            end
            MODE_LOAD: begin
                valid_nxt_s    = id_valid;
                pc_nxt_s       = id_pc;
                rd1_nxt_s      = id_rd1;
                rd2_nxt_s      = id_rd2;
                imm_nxt_s      = id_imm;
                rs1_nxt_s      = id_rs1;
                rs2_nxt_s      = id_rs2;
                rd_nxt_s       = id_rd;
                use_rs1_nxt_s  = id_use_rs1;
                use_rs2_nxt_s  = id_use_rs2;
                funct3_nxt_s   = id_funct3;
                regwrite_nxt_s = id_RegWrite & id_valid;
                memwrite_nxt_s = id_MemWrite & id_valid;
                memread_nxt_s  = id_MemRead & id_valid;
                alusrc_nxt_s   = id_ALUSrc;
                aluop_nxt_s    = id_ALUOp;
                npcop_nxt_s    = id_valid ? id_NPCOp : 5'd0;
                wdsel_nxt_s    = id_WDSel;
            end
            default: begin
                cnt_nxt_s = cnt_r;
            end
        endcase
    end

    // EX-stage state register, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_r    <= 1'b0;
            pc_r       <= 32'd0;
            rd1_r      <= 32'd0;
            rd2_r      <= 32'd0;
            imm_r      <= 32'd0;
            rs1_r      <= 5'd0;
            rs2_r      <= 5'd0;
            rd_r       <= 5'd0;
            use_rs1_r  <= 1'b0;
            use_rs2_r  <= 1'b0;
            funct3_r   <= 3'd0;
            regwrite_r <= 1'b0;
            memwrite_r <= 1'b0;
            memread_r  <= 1'b0;
            alusrc_r   <= 1'b0;
            aluop_r    <= 5'd0;
            npcop_r    <= 5'd0;
            wdsel_r    <= 2'd0;
            cnt_r      <= 16'd0;
        end else begin
            valid_r    <= valid_nxt_s;
            pc_r       <= pc_nxt_s;
            rd1_r      <= rd1_nxt_s;
            rd2_r      <= rd2_nxt_s;
            imm_r      <= imm_nxt_s;
            rs1_r      <= rs1_nxt_s;
            rs2_r      <= rs2_nxt_s;
            rd_r       <= rd_nxt_s;
            use_rs1_r  <= use_rs1_nxt_s;
            use_rs2_r  <= use_rs2_nxt_s;
            funct3_r   <= funct3_nxt_s;
            regwrite_r <= regwrite_nxt_s;
            memwrite_r <= memwrite_nxt_s;
            memread_r  <= memread_nxt_s;
            alusrc_r   <= alusrc_nxt_s;
            aluop_r    <= aluop_nxt_s;
            npcop_r    <= npcop_nxt_s;
            wdsel_r    <= wdsel_nxt_s;
            cnt_r      <= cnt_nxt_s;
        end
    end

    assign ex_valid    = valid_r;
    assign ex_pc       = pc_r;
    assign ex_rd1      = rd1_r;
    assign ex_rd2      = rd2_r;
    assign ex_imm      = imm_r;
    assign ex_rs1      = rs1_r;
    assign ex_rs2      = rs2_r;
    assign ex_rd       = rd_r;
    assign ex_use_rs1  = use_rs1_r;
    assign ex_use_rs2  = use_rs2_r;
    assign ex_funct3   = funct3_r;
    assign ex_RegWrite = regwrite_r;
    assign ex_MemWrite = memwrite_r;
    assign ex_MemRead  = memread_r;
    assign ex_ALUSrc   = alusrc_r;
    assign ex_ALUOp    = aluop_r;
    assign ex_NPCOp    = npcop_r;
    assign ex_WDSel    = wdsel_r;
    assign bubble_cnt  = cnt_r;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Randomized and directed bench for id_ex_pipe against a behavioural pipeline model;
// expectations follow LOAD_USE_DETECT_EN the same way the design build does.
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        id_valid, id_use_rs1, id_use_rs2, id_RegWrite, id_MemWrite, id_MemRead, id_ALUSrc;
    logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd, id_ALUOp, id_NPCOp;
    logic [2:0]  id_funct3;
    logic [1:0]  id_WDSel;
    logic        flush, hold;
    logic        ex_valid, ex_use_rs1, ex_use_rs2, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc;
    logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_ALUOp, ex_NPCOp;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_WDSel;
    logic        load_use_stall;
    logic [15:0] bubble_cnt;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef LOAD_USE_DETECT_EN
    localparam bit DETECT = 1'b1;
`else
    localparam bit DETECT = 1'b0;
`endif

    // Reference model: what the EX stage is expected to hold.
    typedef struct {
        bit        valid, use1, use2, rw, mw, mr, alusrc;
        bit [31:0] pc, rd1, rd2, imm;
        bit [4:0]  rs1, rs2, rd, aluop, npcop;
        bit [2:0]  f3;
        bit [1:0]  wdsel;
        int        bubbles;
    } ex_model_t;
    ex_model_t m;

    id_ex_pipe dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1),
        .id_rd2(id_rd2), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_funct3(id_funct3),
        .id_RegWrite(id_RegWrite), .id_MemWrite(id_MemWrite), .id_MemRead(id_MemRead),
        .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp), .id_NPCOp(id_NPCOp), .id_WDSel(id_WDSel),
        .flush(flush), .hold(hold), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1),
        .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_use_rs1(ex_use_rs1), .ex_use_rs2(ex_use_rs2), .ex_funct3(ex_funct3),
        .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite), .ex_MemRead(ex_MemRead),
        .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .ex_NPCOp(ex_NPCOp), .ex_WDSel(ex_WDSel),
        .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_hazard();
        bit reads_rd;
        reads_rd = (id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd);
        return DETECT && m.valid && m.mr && m.rd != 5'd0 && id_valid && reads_rd;
    endfunction

    task automatic model_clear();
        m = '{default: 0};
    endtask

    task automatic model_edge(input bit hz);
        if (hold) return;
        if (flush || hz) begin
            m.valid = 0; m.rw = 0; m.mw = 0; m.mr = 0; m.npcop = 0; m.wdsel = 0;
            m.bubbles = (m.bubbles >= 65535) ? 65535 : m.bubbles + 1;
        end else begin
            m.valid = id_valid; m.pc = id_pc; m.rd1 = id_rd1; m.rd2 = id_rd2; m.imm = id_imm;
            m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd; m.use1 = id_use_rs1; m.use2 = id_use_rs2;
            m.f3 = id_funct3; m.alusrc = id_ALUSrc; m.aluop = id_ALUOp; m.wdsel = id_WDSel;
            m.rw = id_valid & id_RegWrite; m.mw = id_valid & id_MemWrite;
            m.mr = id_valid & id_MemRead;  m.npcop = id_valid ? id_NPCOp : 5'd0;
        end
    endtask

    task automatic compare_all();
        check_val("ex_valid", ex_valid, m.valid);
        check_val("ex_RegWrite", ex_RegWrite, m.rw);
        check_val("ex_MemWrite", ex_MemWrite, m.mw);
        check_val("ex_MemRead", ex_MemRead, m.mr);
        check_val("ex_NPCOp", ex_NPCOp, m.npcop);
        check_val("bubble_cnt", bubble_cnt, m.bubbles);
        if (m.valid) begin
            check_val("ex_pc", ex_pc, m.pc);
            check_val("ex_rd1", ex_rd1, m.rd1);
            check_val("ex_rd2", ex_rd2, m.rd2);
            check_val("ex_imm", ex_imm, m.imm);
            check_val("ex_regs", {ex_rs1, ex_rs2, ex_rd}, {m.rs1, m.rs2, m.rd});
            check_val("ex_uses", {ex_use_rs1, ex_use_rs2}, {m.use1, m.use2});
            check_val("ex_alu", {ex_funct3, ex_ALUSrc, ex_ALUOp}, {m.f3, m.alusrc, m.aluop});
            check_val("ex_WDSel", ex_WDSel, m.wdsel);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ctl"}, {ex_valid, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc,
                                 ex_use_rs1, ex_use_rs2, load_use_stall}, 32'd0);
        check_val({tag, "_data"}, ex_pc | ex_rd1 | ex_rd2 | ex_imm, 32'd0);
        check_val({tag, "_fields"}, {ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_ALUOp, ex_NPCOp, ex_WDSel},
                  32'd0);
        check_val({tag, "_cnt"}, bubble_cnt, 32'd0);
    endtask

    // One cycle: inputs already driven before the edge; check stall, clock, check EX.
    task automatic cycle();
        bit hz;
        #1;
        hz = model_hazard();
        check_val("load_use_stall", load_use_stall, hz & ~flush);
        @(posedge clk);
        model_edge(hz);
        #1;
        compare_all();
    endtask

    task automatic set_instr(input bit v, input bit mr, input bit rw, input logic [4:0] rd,
                             input logic [4:0] rs1, input bit u1, input logic [4:0] rs2, input bit u2);
        @(negedge clk);
        id_valid = v; id_MemRead = mr; id_RegWrite = rw; id_rd = rd;
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_MemWrite = 1'b0; id_NPCOp = 5'd0; id_WDSel = mr ? 2'd1 : 2'd0;
        id_pc = id_pc + 32'd4; id_imm = $urandom; id_rd1 = $urandom; id_rd2 = $urandom;
    endtask

    task automatic rand_inputs();
        @(negedge clk);
        id_valid = ($urandom_range(0, 9) < 8); id_pc = $urandom; id_rd1 = $urandom;
        id_rd2 = $urandom; id_imm = $urandom;
        id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
        id_rd = 5'($urandom_range(0, 3));
        id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom); id_funct3 = 3'($urandom);
        id_RegWrite = 1'($urandom); id_MemWrite = 1'($urandom);
        id_MemRead = ($urandom_range(0, 9) < 4); id_ALUSrc = 1'($urandom);
        id_ALUOp = 5'($urandom); id_NPCOp = 5'($urandom); id_WDSel = 2'($urandom);
        flush = ($urandom_range(0, 9) == 0); hold = ($urandom_range(0, 6) == 0);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 check_all_zero(tag);
        model_clear();
        @(negedge clk);
        #2 rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; hold = 1'b0;
        {id_valid, id_use_rs1, id_use_rs2, id_RegWrite, id_MemWrite, id_MemRead, id_ALUSrc} = '0;
        {id_pc, id_rd1, id_rd2, id_imm} = '0;
        {id_rs1, id_rs2, id_rd, id_ALUOp, id_NPCOp, id_funct3, id_WDSel} = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        // lw x5 followed by add x6,x5,x1
        set_instr(1, 1, 1, 5'd5, 5'd2, 1, 5'd0, 0); cycle();
        set_instr(1, 0, 1, 5'd6, 5'd5, 1, 5'd1, 1); cycle();
        check_val("lu_bubble_cnt", bubble_cnt, DETECT ? 32'd1 : 32'd0);
        if (DETECT) begin
            set_instr(1, 0, 1, 5'd6, 5'd5, 1, 5'd1, 1); cycle();
        end
        check_val("lu_consumer", {ex_valid, ex_rs1, ex_RegWrite}, {1'b1, 5'd5, 1'b1});

        // load to x0 never stalls; sw data path depends only on use_rs2
        set_instr(1, 1, 1, 5'd0, 5'd0, 0, 5'd0, 0); cycle();
        set_instr(1, 0, 1, 5'd7, 5'd0, 1, 5'd0, 1); cycle();
        set_instr(1, 1, 1, 5'd5, 5'd0, 0, 5'd0, 0); cycle();
        set_instr(1, 0, 0, 5'd0, 5'd3, 1, 5'd5, 0); cycle();
        set_instr(1, 1, 1, 5'd5, 5'd0, 0, 5'd0, 0); cycle();
        set_instr(1, 0, 0, 5'd0, 5'd3, 1, 5'd5, 1); cycle();

        // hazard together with flush: no stall, single bubble
        set_instr(1, 1, 1, 5'd5, 5'd0, 0, 5'd0, 0); cycle();
        set_instr(1, 0, 1, 5'd6, 5'd5, 1, 5'd1, 0); flush = 1'b1; cycle();
        flush = 1'b0;

        // hazard held for three cycles, then released
        set_instr(1, 1, 1, 5'd9, 5'd0, 0, 5'd0, 0); cycle();
        set_instr(1, 0, 1, 5'd6, 5'd9, 1, 5'd1, 0); hold = 1'b1;
        repeat (3) cycle();
        hold = 1'b0;
        repeat (2) cycle();

        // reset while a load-use stall is pending
        set_instr(1, 1, 1, 5'd4, 5'd0, 0, 5'd0, 0); cycle();
        set_instr(1, 0, 1, 5'd6, 5'd4, 1, 5'd0, 0);
        pulse_reset("reset_mid_stall");
        cycle();

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            if (i == 1500) begin
                hold = 1'b0; flush = 1'b0;
                pulse_reset("reset_traffic");
            end
            cycle();
        end

        // saturation: keep flushing past 65536 bubbles
        @(negedge clk);
        hold = 1'b0; flush = 1'b1;
        repeat (65540) @(posedge clk);
        m.valid = 0; m.rw = 0; m.mw = 0; m.mr = 0; m.npcop = 0; m.wdsel = 0; m.bubbles = 65535;
        #1 compare_all();
        check_val("cnt_saturated", bubble_cnt, 32'h0000FFFF);
        @(negedge clk);
        flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
